l1ca_signal_gen: RTL and testbench
==================================

Name: l1ca_signal_gen

Overview:
- Synthesizes a 1-bit GPS L1 C/A IF sample stream for one SV, at a programmable code phase, carrier rate and noise level.
- It is the transmit-side counterpart of the L1 C/A acquisition search. Its sample_out drives the search's signal_in in bench and on-chip loopback self-test.
- Output is a burst of N_SAMPLES samples, one per clk, after a start pulse.

Parameters:
- N_SAMPLES, 19200, samples per burst (one 1 ms epoch at the acquisition sample rate).
- LFSR_W, 32, width of the noise LFSR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- sv  in  sv_t  SV whose PRN is generated
- code_start  in  11  initial code phase in half-chips, 0..2045
- code_rate  in  32  code NCO increment per sample
- lo_rate  in  32  carrier NCO increment per sample
- noise_thresh  in  8  flip probability = noise_thresh/256
- seed  in  32  LFSR seed
- sample_out  out  1  generated sample
- sample_valid  out  1  high for each burst sample
- code_chip  out  10  current chip index, for debug/verification
- busy  out  1  high in WIND and RUN
- done  out  1  set at burst end; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port rst.
- Reset values: state=IDLE; sample_out=0, sample_valid=0, busy=0, done=0. All NCO phases, counters and latched inputs = 0. LFSR=1.
- Reset mid-burst: abort; sample_valid=0 from the next edge. There is no partial done.
- IDLE, on start:
  - Latch sv, code_rate, lo_rate, noise_thresh.
  - Latch code_start; a value ≥2046 is replaced by 0.
  - Load LFSR with seed; seed 0 is replaced by 1.
  - Pulse clear to the l1ca_code instance. Clear done. Go to WIND.
- WIND:
  - Strobe the code generator each cycle until chip == code_start[10:1].
  - On the match cycle: stop the strobe; set code_phase = code_start[0] ? 0x8000_0000 : 0; set lo_phase=0 and sample_ctr=0; go to RUN.
  - Wind length = code_start[10:1] cycles. The first sample_valid appears at cycle 2+code_start[10:1] after the start cycle.
- RUN, per cycle:
  - Registered output: sample_out = code ^ LO_SIN[lo_phase[31:30]] ^ flip, where flip = (lfsr[7:0] < noise_thresh). sample_valid=1.
  - Update lo_phase += lo_rate (mod 2^32).
  - Compute {carry,code_phase} = code_phase + code_rate in 33 bits; carry strobes the code generator for exactly one cycle.
  - Advance the LFSR once: Galois, x^32+x^22+x^2+x+1.
  - Increment sample_ctr.
- RUN exit: at sample_ctr == N_SAMPLES-1, the last sample is issued. Next cycle: sample_valid=0, done=1, state=IDLE.
- Guarantee: sample_valid is high for exactly N_SAMPLES consecutive cycles, with no gaps.
- Chip wrap: chip wraps 1022→0 inside l1ca_code. Phase arithmetic is modular; no saturation.
- Start is ignored while busy. Start on the same cycle as rst: rst wins.
- noise_thresh=0 gives a noiseless output; noise_thresh=255 flips the sample with probability 255/256.

Decomposition:
- common_gnss_types_pkg: LO_SIN (4'b0011), LO_COS (4'b1001), nominal CODE_RATE (228841226), the N_DOP LO_RATE table, and the N_SAMPLES default. The acquisition search uses the same constants.
- Reused sub-module: l1ca_code, with nrst tied to ~rst.
- New sub-module: gnss_noise_lfsr, a seeded Galois LFSR with an advance enable.

Test Plan:
- Noiseless bin 6, phase 0: sv=1, code_start=0, code_rate=228841226, lo_rate=898811385, noise_thresh=0 → first valid 2 cycles after start; exactly 19200 valid cycles; then done=1. Looped into l1ca_search: code_index=0, dop_index=6.
- Odd code phase: same as above but code_start=1001 → first valid at cycle 502 after start; l1ca_search reports code_index 1001±1, dop_index 6.
- Frozen NCOs: code_rate=0, lo_rate=0, sv=1 → code_chip stays 0; sample_out constant 0 (PRN1 chip0=1 ^ LO_SIN[0]=1) for all 19200 samples.
- Code wrap: code_rate=0x8000_0000 → code_chip advances every 2 valid cycles; wraps 1022→0 after 2046 samples.
- Noise statistics: noise_thresh=128, seed=0xACE1 → mismatches vs a noiseless run with the same settings = 9600±400. A second run with the same seed is bit-identical.
- Control corner cases: start while busy is ignored (valid count stays 19200). rst mid-RUN → sample_valid=0 and done=0 next cycle. A following start produces a full fresh burst.

Source files
------------

// File: rtl/common_gnss_types_pkg.sv
// Constants and types shared by the L1 C/A signal generator and the acquisition search.
// Both sides must agree on the LO tables, code rate and Doppler bin plan.
package common_gnss_types_pkg;

   typedef logic [5:0] sv_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WIND,
      ST_RUN
   } gen_state_t;

   localparam logic [3:0]  LO_SIN        = 4'b0011;
   localparam logic [3:0]  LO_COS        = 4'b1001;
   localparam logic [31:0] CODE_RATE     = 32'd228841226;
   localparam int          N_DOP         = 13;
   localparam int          N_SAMPLES_DEF = 19200;
   localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

   // G2 phase-selector stage pairs for PRN 1..32, one nibble per stage number.
   localparam logic [0:31][7:0] G2_TAPS = {
      8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2a, 8'h18, 8'h29,
      8'h3a, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9a,
      8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
      8'h57, 8'h68, 8'h79, 8'h8a, 8'h16, 8'h27, 8'h38, 8'h49
   };

   function automatic logic [7:0] g2_taps(input sv_t sv);
      logic [4:0] idx;
      idx = (sv >= 6'd1 && sv <= 6'd32) ? 5'(sv - 6'd1) : 5'd0;
      return G2_TAPS[idx];
   endfunction

   // Doppler bin k: 4.0 MHz IF + 3 kHz * k, at a 19.2 MHz sample rate.
   function automatic logic [31:0] lo_rate_bin(input int unsigned k);
      logic [63:0] f;
      f = 64'(32'd4_000_000 + 32'd3000 * k);
      return 32'((f << 32) / 64'd19_200_000);
   endfunction

endpackage

// File: rtl/gnss_noise_lfsr.sv
// Seeded Galois LFSR producing a per-sample flip decision with probability thresh/256.
module gnss_noise_lfsr
   import common_gnss_types_pkg::*;
#(
   parameter int LFSR_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   input  logic [7:0]        thresh,
   output logic              flip
);

   logic [LFSR_W-1:0] lfsr;

   assign flip = (lfsr[7:0] < thresh);

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_W'(1);
      end else if (load) begin
         lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
      end else if (advance) begin
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_W'(LFSR_TAPS) : '0);
      end
   end

endmodule

// File: rtl/l1ca_code.sv
// GPS L1 C/A Gold code generator: G1/G2 shift registers advanced by a strobe,
// with the current chip value and chip index.
module l1ca_code
   import common_gnss_types_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       clear,
   input  logic       strobe,
   input  sv_t        sv,
   output logic       code,
   output logic [9:0] chip
);

   logic [10:1] g1;
   logic [10:1] g2;
   logic [7:0]  taps;

   assign taps = g2_taps(sv);
   assign code = g1[10] ^ g2[taps[7:4]] ^ g2[taps[3:0]];

   always_ff @(posedge clk) begin
      if (!nrst || clear) begin
         g1   <= '1;
         g2   <= '1;
         chip <= '0;
      end else if (strobe) begin
         g1   <= {g1[9:1], g1[3] ^ g1[10]};
         g2   <= {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
         chip <= (chip == 10'd1022) ? 10'd0 : chip + 10'd1;
      end
   end

endmodule

// File: rtl/l1ca_signal_gen.sv
// One-SV 1-bit L1 C/A IF sample burst generator: code winds to the start phase,
// then code NCO, carrier NCO and LFSR noise combine into one sample per clock.
module l1ca_signal_gen
   import common_gnss_types_pkg::*;
#(
   parameter int N_SAMPLES = N_SAMPLES_DEF,
   parameter int LFSR_W    = 32
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  sv_t         sv,
   input  logic [10:0] code_start,
   input  logic [31:0] code_rate,
   input  logic [31:0] lo_rate,
   input  logic [7:0]  noise_thresh,
   input  logic [31:0] seed,
   output logic        sample_out,
   output logic        sample_valid,
   output logic [9:0]  code_chip,
   output logic        busy,
   output logic        done
);

   localparam int CTR_W = $clog2(N_SAMPLES);

   gen_state_t       state, state_nxt;
   sv_t              sv_q;
   logic [10:0]      code_start_q;
   logic [31:0]      code_rate_q, lo_rate_q;
   logic [7:0]       thresh_q;
   logic [31:0]      code_phase, lo_phase;
   logic [CTR_W-1:0] sample_ctr;
   logic [32:0]      phase_sum;
   logic             accept, chip_match, last_sample;
   logic             code_strobe, code_bit, noise_flip;

   assign accept      = (state == ST_IDLE) && start;
   assign chip_match  = (code_chip == code_start_q[10:1]);
   assign last_sample = (sample_ctr == CTR_W'(N_SAMPLES - 1));
   assign phase_sum   = {1'b0, code_phase} + {1'b0, code_rate_q};
   assign busy        = (state == ST_WIND) || (state == ST_RUN);

   always_comb begin
      state_nxt   = state;
      code_strobe = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_WIND;
         ST_WIND: begin
            if (chip_match) state_nxt = ST_RUN;
            else            code_strobe = 1'b1;
         end
         ST_RUN: begin
            code_strobe = phase_sum[32];
            if (last_sample) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         sv_q         <= '0;
         code_start_q <= '0;
         code_rate_q  <= '0;
         lo_rate_q    <= '0;
         thresh_q     <= '0;
         code_phase   <= '0;
         lo_phase     <= '0;
         sample_ctr   <= '0;
         sample_out   <= 1'b0;
         sample_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         sample_valid <= (state == ST_RUN);
         if (accept) begin
            sv_q         <= sv;
            code_start_q <= (code_start >= 11'd2046) ? 11'd0 : code_start;
            code_rate_q  <= code_rate;
            lo_rate_q    <= lo_rate;
            thresh_q     <= noise_thresh;
            done         <= 1'b0;
         end else if (state == ST_IDLE && sample_valid) begin
            // the cycle after the final sample leaves RUN
            done <= 1'b1;
         end
         if (state == ST_WIND && chip_match) begin
            code_phase <= code_start_q[0] ? 32'h8000_0000 : 32'd0;
            lo_phase   <= '0;
            sample_ctr <= '0;
         end
         if (state == ST_RUN) begin
            sample_out <= code_bit ^ LO_SIN[lo_phase[31:30]] ^ noise_flip;
            lo_phase   <= lo_phase + lo_rate_q;
            code_phase <= phase_sum[31:0];
            sample_ctr <= sample_ctr + CTR_W'(1);
         end
      end
   end

   l1ca_code u_code (
      .clk    (clk),
      .nrst   (~rst),
      .clear  (accept),
      .strobe (code_strobe),
      .sv     (sv_q),
      .code   (code_bit),
      .chip   (code_chip)
   );

   gnss_noise_lfsr #(.LFSR_W(LFSR_W)) u_noise (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .seed    (LFSR_W'(seed)),
      .advance (state == ST_RUN),
      .thresh  (thresh_q),
      .flip    (noise_flip)
   );

endmodule

// File: tb/tb_l1ca_signal_gen.sv
// Bench for l1ca_signal_gen: directed and random bursts checked sample-by-sample
// against a sequence-level model of the C/A code, carrier sign and noise flips.
module tb_l1ca_signal_gen;
   import common_gnss_types_pkg::*;

   localparam int N          = 2400;
   localparam int WIND_LIMIT = 1100;

   logic        clk = 1'b0;
   logic        rst, start;
   sv_t         sv;
   logic [10:0] code_start;
   logic [31:0] code_rate, lo_rate, seed;
   logic [7:0]  noise_thresh;
   logic        sample_out, sample_valid, busy, done;
   logic [9:0]  code_chip;

   int checks   = 0;
   int failures = 0;

   bit g1seq [1023];
   bit g2seq [1023];
   int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
   int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

   int          cfg_sv, cfg_cs;
   logic [31:0] cfg_cr, cfg_lr, cfg_seed;
   logic [7:0]  cfg_th;
   bit          cap   [N];
   bit          cap_a [N];
   int          last_ones, last_diff;

   always #5 clk = ~clk;

   l1ca_signal_gen #(.N_SAMPLES(N), .LFSR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sv           (sv),
      .code_start   (code_start),
      .code_rate    (code_rate),
      .lo_rate      (lo_rate),
      .noise_thresh (noise_thresh),
      .seed         (seed),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .code_chip    (code_chip),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10 as output-sequence recurrences.
   task automatic build_seqs();
      for (int t = 0; t < 10; t++) begin
         g1seq[t] = 1'b1;
         g2seq[t] = 1'b1;
      end
      for (int t = 0; t < 1013; t++) begin
         g1seq[t+10] = g1seq[t+7] ^ g1seq[t];
         g2seq[t+10] = g2seq[t+8] ^ g2seq[t+7] ^ g2seq[t+4] ^ g2seq[t+2] ^ g2seq[t+1] ^ g2seq[t];
      end
   endtask

   function automatic bit ca_bit(input int prn, input int c);
      return g1seq[c] ^ g2seq[(c + 10 - tap_a[prn-1]) % 1023]
                      ^ g2seq[(c + 10 - tap_b[prn-1]) % 1023];
   endfunction

   // Chip used by sample n: start chip plus whole code-NCO wraps accumulated over n samples.
   function automatic int model_chip(input int n, input int eff_cs, input logic [31:0] cr);
      logic [63:0] p;
      p = ((eff_cs % 2) == 1 ? 64'h8000_0000 : 64'd0) + 64'(n) * {32'd0, cr};
      return int'((64'(eff_cs / 2) + {32'd0, p[63:32]}) % 64'd1023);
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v % 2 == 1) ? ((v / 2) ^ 32'h8020_0003) : (v / 2);
   endfunction

   task automatic burst(input string tag, input bit poke);
      int eff_cs, lat, n, s_err, c_err, ones, diff;
      logic [31:0] lf, ph;
      bit clean, expv;
      eff_cs = (cfg_cs >= 2046) ? 0 : cfg_cs;
      lf     = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
      @(negedge clk);
      sv = 6'(cfg_sv); code_start = 11'(cfg_cs); code_rate = cfg_cr;
      lo_rate = cfg_lr; noise_thresh = cfg_th; seed = cfg_seed; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".done_clr"}, 64'(done), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      lat = 0;
      while (!sample_valid && lat < WIND_LIMIT) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(2 + eff_cs / 2));
      n = 0; s_err = 0; c_err = 0; ones = 0; diff = 0;
      while (sample_valid && n < N + 8) begin
         ph    = 32'(n) * cfg_lr;
         clean = ca_bit(cfg_sv, model_chip(n, eff_cs, cfg_cr)) ^ (ph < 32'h8000_0000);
         expv  = clean ^ ((lf % 256) < {24'd0, cfg_th});
         if (sample_out !== expv) s_err++;
         if (sample_out !== clean) diff++;
         if (32'(code_chip) !== 32'(model_chip(n + 1, eff_cs, cfg_cr))) c_err++;
         if (sample_out === 1'b1) ones++;
         if (n < N) cap[n] = sample_out;
         if (poke && n == 100) begin
            start = 1'b1; sv = 6'($urandom_range(32, 1)); code_rate = $urandom;
            lo_rate = $urandom; noise_thresh = 8'($urandom); code_start = 11'($urandom);
         end
         if (poke && n == 101) start = 1'b0;
         lf = lfsr_step(lf);
         n++;
         @(negedge clk);
      end
      chk({tag, ".count"}, 64'(n), 64'(N));
      chk({tag, ".sample_err"}, 64'(s_err), 64'd0);
      chk({tag, ".chip_err"}, 64'(c_err), 64'd0);
      chk({tag, ".valid_end"}, 64'(sample_valid), 64'd0);
      chk({tag, ".done"}, 64'(done), 64'd1);
      chk({tag, ".busy_end"}, 64'(busy), 64'd0);
      last_ones = ones;
      last_diff = diff;
   endtask

   task automatic rand_cfg();
      cfg_sv   = $urandom_range(32, 1);
      cfg_cs   = $urandom_range(2047, 0);
      cfg_cr   = $urandom;
      cfg_lr   = $urandom;
      cfg_th   = 8'($urandom_range(255, 0));
      cfg_seed = $urandom;
   endtask

   initial begin
      int lat, mism;
      build_seqs();
      rst = 1'b1; start = 1'b0; sv = '0; code_start = '0; code_rate = '0;
      lo_rate = '0; noise_thresh = '0; seed = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset.valid", 64'(sample_valid), 64'd0);
      chk("reset.sample", 64'(sample_out), 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.chip", 64'(code_chip), 64'd0);

      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_start.busy", 64'(busy), 64'd0);

      cfg_sv = 1; cfg_cs = 0; cfg_cr = 32'd228841226; cfg_lr = 32'd898811385;
      cfg_th = 8'd0; cfg_seed = 32'd1;
      burst("bin6_ph0", 1'b0);
      repeat (4) @(negedge clk);
      chk("done_hold", 64'(done), 64'd1);

      cfg_cs = 1001;
      burst("odd_phase", 1'b0);

      cfg_cs = 0; cfg_cr = 32'd0; cfg_lr = 32'd0;
      burst("frozen", 1'b0);
      chk("frozen.ones", 64'(last_ones), 64'd0);

      cfg_sv = 7; cfg_cr = 32'h8000_0000; cfg_lr = 32'd898811385;
      burst("code_wrap", 1'b0);

      cfg_sv = 1; cfg_cr = 32'd228841226; cfg_th = 8'd128; cfg_seed = 32'h0000_ACE1;
      burst("noise_a", 1'b0);
      chk("noise.stat_in_range", 64'(last_diff > N / 2 - N / 12 && last_diff < N / 2 + N / 12), 64'd1);
      cap_a = cap;
      burst("noise_b", 1'b0);
      mism = 0;
      for (int i = 0; i < N; i++) if (cap[i] != cap_a[i]) mism++;
      chk("noise.repeat_identical", 64'(mism), 64'd0);

      cfg_sv = 12; cfg_cs = 2047; cfg_th = 8'd255; cfg_seed = 32'd0;
      burst("clip_seed0_th255", 1'b0);

      rand_cfg();
      burst("busy_poke", 1'b1);

      rand_cfg();
      cfg_cs = $urandom_range(40, 0);
      @(negedge clk);
      sv = 6'(cfg_sv); code_start = 11'(cfg_cs); code_rate = cfg_cr;
      lo_rate = cfg_lr; noise_thresh = cfg_th; seed = cfg_seed; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!sample_valid && lat < WIND_LIMIT) begin
         @(negedge clk);
         lat++;
      end
      repeat (50) @(negedge clk);
      chk("rst_mid.running", 64'(sample_valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid.valid", 64'(sample_valid), 64'd0);
      chk("rst_mid.done", 64'(done), 64'd0);
      chk("rst_mid.busy", 64'(busy), 64'd0);

      rand_cfg();
      burst("fresh_after_rst", 1'b0);
      rand_cfg();
      burst("random_a", 1'b0);
      rand_cfg();
      burst("random_b", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
